tri_bus_arbiter: RTL

TRI_BUS_ARBITER -- requirements
Module: tri_bus_arbiter

---
 rtl/tri_bus_arbiter.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/tri_bus_arbiter.sv
// Round-robin arbiter for a shared 4-driver tri-state bus, with a mandatory
// turnaround gap between owners and a hold limit that lets waiting requesters pre-empt.
module tri_bus_arbiter #(
    parameter int MAX_HOLD = 8,
    parameter int TURN_CYC = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    output logic [3:0] gnt,
    output logic [1:0] sel,
    output logic       bus_en,
    output logic       busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_TURN  = 2'd1,
        S_GRANT = 2'd2
    } state_t;

    localparam logic [3:0] HOLD_MAX = 4'(MAX_HOLD);
    // From IDLE the arbitration cycle itself adds one cycle before TURN counts down;
    // on a hand-over the previous owner's exit edge already serves that role.
    localparam logic [1:0] TURN_LD_IDLE = 2'(TURN_CYC);
    localparam logic [1:0] TURN_LD_HAND = 2'(TURN_CYC - 1);

    state_t     r_state;
    logic [1:0] r_sel;
    logic [1:0] r_last;
    logic [3:0] r_hold;
    logic [1:0] r_turn;
    logic [3:0] r_gnt;
    logic       r_bus_en;
    logic       r_busy;

    state_t     w_state_nxt;
    logic [1:0] w_sel_nxt;
    logic [1:0] w_last_nxt;
    logic [3:0] w_hold_nxt;
    logic [1:0] w_turn_nxt;
    logic [3:0] w_gnt_nxt;
    logic [3:0] w_sel_oh;
    logic [3:0] w_hold_inc;
    logic [1:0] w_pick;
    logic       w_others;
    logic       w_leave;

    function automatic logic [1:0] f_pick(input logic [3:0] q, input logic [1:0] last);
        logic [1:0] idx;
        logic [1:0] win;
        logic       found;
        win   = last;
        found = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            idx = last + 2'(k);
            if (!found && q[idx]) begin
                win   = idx;
                found = 1'b1;
            end
        end
        return win;
    endfunction

    function automatic logic [3:0] f_hold_sat(input logic [3:0] h);
        return (h >= HOLD_MAX) ? HOLD_MAX : h + 4'd1;
    endfunction

    assign w_sel_oh   = 4'b0001 << r_sel;
    assign w_pick     = f_pick(req, r_last);
    assign w_others   = |(req & ~w_sel_oh);
    assign w_hold_inc = f_hold_sat(r_hold);
    assign w_leave    = !req[r_sel] || ((w_hold_inc == HOLD_MAX) && w_others);

    always_comb begin
        w_state_nxt = r_state;
        w_sel_nxt   = r_sel;
        w_last_nxt  = r_last;
        w_hold_nxt  = r_hold;
        w_turn_nxt  = r_turn;
        w_gnt_nxt   = 4'b0000;
        case (r_state)
            S_IDLE: begin
                if (|req) begin
                    w_sel_nxt   = w_pick;
                    w_turn_nxt  = TURN_LD_IDLE;
                    w_state_nxt = S_TURN;
                end
            end
            S_TURN: begin
                if (r_turn == 2'd0) begin
                    if (req[r_sel]) begin
                        w_state_nxt = S_GRANT;
                        w_gnt_nxt   = w_sel_oh;
                        w_last_nxt  = r_sel;
                        w_hold_nxt  = 4'd0;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end else begin
                    w_turn_nxt = r_turn - 2'd1;
                end
            end
            S_GRANT: begin
                w_hold_nxt = w_hold_inc;
                if (w_leave) begin
                    if (w_others) begin
                        // r_last equals r_sel here, so the current owner is searched last
                        w_sel_nxt   = w_pick;
                        w_turn_nxt  = TURN_LD_HAND;
                        w_state_nxt = S_TURN;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end else begin
                    w_gnt_nxt = w_sel_oh;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_sel    <= 2'd0;
            r_last   <= 2'd3;
            r_hold   <= 4'd0;
            r_turn   <= 2'd0;
            r_gnt    <= 4'b0000;
            r_bus_en <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_sel    <= w_sel_nxt;
            r_last   <= w_last_nxt;
            r_hold   <= w_hold_nxt;
            r_turn   <= w_turn_nxt;
            r_gnt    <= w_gnt_nxt;
            r_bus_en <= |w_gnt_nxt;
            r_busy   <= (w_state_nxt != S_IDLE);
        end
    end

    assign gnt    = r_gnt;
    assign sel    = r_sel;
    assign bus_en = r_bus_en;
    assign busy   = r_busy;

endmodule
